// File: rtl/johnson_seq_decoder_if.sv
// Signal bundle between a 4-bit Johnson ring and its receive-side sequence checker.
// The ring side drives q_in; the checker drives the decoded status back.
interface johnson_seq_decoder_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       q_in;
  logic [2:0]       step;
  logic             step_valid;
  logic             step_strobe;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  modport master (
    output q_in,
    input  step, step_valid, step_strobe, seq_err, err_count, locked
  );

  modport slave (
    input  q_in,
    output step, step_valid, step_strobe, seq_err, err_count, locked
  );
endinterface

// File: rtl/johnson_seq_decoder.sv
// Receive-side checker for a 4-bit Johnson ring: synchronise, debounce, decode to a
// step index and verify that each accepted step is the legal successor of the last.
module johnson_seq_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int LOCK_N     = 3,
  parameter int ERR_W      = 8
) (
  input  logic                exCLK,
  input  logic                rst,
  johnson_seq_decoder_if.slave bus
);

  localparam int CNT_W  = $clog2(STABLE_CYC) + 1;
  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_N);
  localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [3:0]        s1_r, s2_r, cand_r, last_pat_r;
  logic              last_vld_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        ref_r;
  logic              ref_vld_r;
  logic [GOOD_W-1:0] good_r, good_nxt_s, good_inc_s;
  logic [2:0]        step_r;
  logic              step_valid_r, step_strobe_r, seq_err_r;
  logic [ERR_W-1:0]  err_count_r;
  logic [3:0]        dec_s;
  logic              legal_s, accept_s, succ_s, err_s;
  logic [2:0]        idx_s;

  // Table lookup: {legal, index} for one ring pattern {QA,QB,QC,QD}.
  function automatic logic [3:0] decode_f(input logic [3:0] pat);
    logic [3:0] res;
    case (pat)
      4'b0000: res = {1'b1, 3'd0};
      4'b1000: res = {1'b1, 3'd1};
      4'b1100: res = {1'b1, 3'd2};
      4'b1110: res = {1'b1, 3'd3};
      4'b1111: res = {1'b1, 3'd4};
      4'b0111: res = {1'b1, 3'd5};
      4'b0011: res = {1'b1, 3'd6};
      4'b0001: res = {1'b1, 3'd7};
      default: res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  assign dec_s   = decode_f(cand_r);
  assign legal_s = dec_s[3];
  assign idx_s   = dec_s[2:0];
  // Accept once the candidate has been stable long enough and is not a repeat.
  assign accept_s = (s2_r == cand_r) && (cnt_r == CNT_MAX) &&
                    (!last_vld_r || (cand_r != last_pat_r));
  assign succ_s   = ref_vld_r && (idx_s == (ref_r + 3'd1));

  // Lock FSM state register.
  always_ff @(posedge exCLK) begin
    if (rst) begin
      state_r <= UNLOCKED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Lock FSM next state, good-step count and error decision for an accepted pattern.
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_r;
    err_s       = 1'b0;
    good_inc_s  = (good_r == GOOD_MAX) ? good_r : (good_r + GOOD_W'(1));
    if (accept_s) begin
      if (!legal_s) begin
        err_s       = 1'b1;
        good_nxt_s  = GOOD_ZERO;
        state_nxt_s = UNLOCKED;
      end else if (!ref_vld_r) begin
        good_nxt_s = GOOD_ZERO;
      end else if (succ_s) begin
        good_nxt_s = good_inc_s;
        case (state_r)
          UNLOCKED: begin
            if (good_inc_s == GOOD_MAX) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s = UNLOCKED;
            end
          end
          LOCKED:  state_nxt_s = LOCKED;
          default: state_nxt_s = UNLOCKED;
        endcase
      end else begin
        err_s       = 1'b1;
        good_nxt_s  = GOOD_ZERO;
        state_nxt_s = UNLOCKED;
      end
    end else begin
      good_nxt_s = good_r;
    end
  end

  // Synchroniser, debounce, reference tracking and registered status outputs.
  always_ff @(posedge exCLK) begin
    if (rst) begin
      s1_r          <= 4'b0000;
      s2_r          <= 4'b0000;
      cand_r        <= 4'b0000;
      cnt_r         <= CNT_ZERO;
      last_pat_r    <= 4'b0000;
      last_vld_r    <= 1'b0;
      ref_r         <= 3'd0;
      ref_vld_r     <= 1'b0;
      good_r        <= GOOD_ZERO;
      step_r        <= 3'd0;
      step_valid_r  <= 1'b0;
      step_strobe_r <= 1'b0;
      seq_err_r     <= 1'b0;
      err_count_r   <= ERR_ZERO;
    end else begin
      s1_r <= bus.q_in;
      s2_r <= s1_r;
      if (s2_r != cand_r) begin
        cand_r <= s2_r;
        cnt_r  <= CNT_ZERO;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      step_strobe_r <= accept_s;
      seq_err_r     <= err_s;
      good_r        <= good_nxt_s;
      if (accept_s) begin
        last_pat_r <= cand_r;
        last_vld_r <= 1'b1;
        if (legal_s) begin
          step_r       <= idx_s;
          step_valid_r <= 1'b1;
          ref_r        <= idx_s;
          ref_vld_r    <= 1'b1;
        end else begin
          step_valid_r <= 1'b0;
          ref_vld_r    <= 1'b0;
        end
      end
      if (err_s && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + ERR_W'(1);
      end
    end
  end

  assign bus.step        = step_r;
  assign bus.step_valid  = step_valid_r;
  assign bus.step_strobe = step_strobe_r;
  assign bus.seq_err     = seq_err_r;
  assign bus.err_count   = err_count_r;
  assign bus.locked      = (state_r == LOCKED);

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Scoreboard bench for johnson_seq_decoder: a pattern-level model predicts each
// acceptance; a negedge monitor pops and compares on every step_strobe.
module tb_johnson_seq_decoder;

  localparam int ERR_W = 8;

  logic exCLK = 1'b0;
  logic rst;

  johnson_seq_decoder_if #(.ERR_W(ERR_W)) bus ();

  johnson_seq_decoder #(
    .STABLE_CYC(4),
    .LOCK_N    (3),
    .ERR_W     (ERR_W)
  ) dut (
    .exCLK(exCLK),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 exCLK = ~exCLK;

  typedef struct packed {
    logic [2:0] step;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests_run  = 0;
  int   fail_cnt   = 0;
  int   strobe_cnt = 0;

  logic [3:0] ring_tbl [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};

  logic       m_last_vld, m_ref_vld, m_valid, m_locked;
  logic [3:0] m_last_pat;
  logic [2:0] m_ref, m_step;
  int         m_good, m_errcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last_vld = 1'b0; m_ref_vld = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
    m_last_pat = 4'b0000; m_ref = 3'd0; m_step = 3'd0; m_good = 0; m_errcnt = 0;
  endtask

  // Pattern-level behaviour: predict what the next acceptance of pat reports.
  task automatic model_accept(input logic [3:0] pat);
    int   idx;
    exp_t e;
    if (m_last_vld && (pat == m_last_pat)) return;
    m_last_vld = 1'b1;
    m_last_pat = pat;
    idx = -1;
    for (int i = 0; i < 8; i++) if (ring_tbl[i] == pat) idx = i;
    e.err = 1'b0;
    if (idx < 0) begin
      e.err = 1'b1; m_valid = 1'b0; m_ref_vld = 1'b0; m_good = 0; m_locked = 1'b0;
    end else if (!m_ref_vld) begin
      m_step = 3'(idx); m_valid = 1'b1; m_ref = 3'(idx); m_ref_vld = 1'b1; m_good = 0;
    end else if (idx == ((int'(m_ref) + 1) % 8)) begin
      m_step = 3'(idx); m_valid = 1'b1; m_ref = 3'(idx);
      if (m_good < 3) m_good++;
      if (m_good == 3) m_locked = 1'b1;
    end else begin
      e.err = 1'b1; m_step = 3'(idx); m_valid = 1'b1; m_ref = 3'(idx); m_good = 0;
      m_locked = 1'b0;
    end
    if (e.err && (m_errcnt != 255)) m_errcnt++;
    e.step  = m_step;
    e.valid = m_valid;
    sb_q.push_back(e);
  endtask

  // Drive a pattern for hold cycles; lat is the cycle index of the first strobe (0 = none).
  task automatic drive_pat(input logic [3:0] pat, input int hold, output int lat);
    @(negedge exCLK);
    bus.q_in = pat;
    model_accept(pat);
    lat = 0;
    for (int i = 1; i <= hold; i++) begin
      @(posedge exCLK);
      #1;
      if ((lat == 0) && (bus.step_strobe === 1'b1)) lat = i;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_step"},        bus.step,        3'd0);
    check_eq({tag, "_step_valid"},  bus.step_valid,  1'b0);
    check_eq({tag, "_step_strobe"}, bus.step_strobe, 1'b0);
    check_eq({tag, "_seq_err"},     bus.seq_err,     1'b0);
    check_eq({tag, "_err_count"},   bus.err_count,   8'd0);
    check_eq({tag, "_locked"},      bus.locked,      1'b0);
  endtask

  // Monitor: every strobe must match the oldest prediction; errors only with a strobe.
  always @(negedge exCLK) begin
    if (rst === 1'b0) begin
      if (bus.step_strobe === 1'b1) begin
        strobe_cnt++;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_strobe", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_step",       bus.step,       mon_e.step);
          check_eq("sb_step_valid", bus.step_valid, mon_e.valid);
          check_eq("sb_seq_err",    bus.seq_err,    mon_e.err);
        end
      end else if (bus.seq_err !== 1'b0) begin
        check_eq("err_without_strobe", bus.seq_err, 1'b0);
      end
    end
  end

  initial begin
    int lat;
    int s0;
    logic [3:0] t1_pats [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};

    rst = 1'b1;
    bus.q_in = 4'b0000;
    model_reset();
    repeat (3) @(posedge exCLK);
    @(negedge exCLK);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Full legal cycle; lock after the 4th accepted step.
    s0 = strobe_cnt;
    for (int k = 0; k < 9; k++) begin
      drive_pat(t1_pats[k], 20, lat);
      check_eq("t1_locked", bus.locked, m_locked);
      check_eq("t1_err_count", bus.err_count, m_errcnt);
    end
    check_eq("t1_strobes", strobe_cnt - s0, 9);

    // Acceptance latency 0000 -> 1000.
    drive_pat(4'b1000, 20, lat);
    check_eq("t2_latency", lat, 7);
    check_eq("t2_step", bus.step, 3'd1);

    // Skip while locked, then relock after three good steps.
    drive_pat(4'b1100, 20, lat);
    check_eq("t3_locked_pre", bus.locked, 1'b1);
    drive_pat(4'b1111, 20, lat);
    check_eq("t3_locked_skip", bus.locked, 1'b0);
    check_eq("t3_err_count", bus.err_count, m_errcnt);
    check_eq("t3_step", bus.step, 3'd4);
    drive_pat(4'b0111, 20, lat);
    check_eq("t3_locked_a", bus.locked, m_locked);
    drive_pat(4'b0011, 20, lat);
    check_eq("t3_locked_b", bus.locked, m_locked);
    drive_pat(4'b0001, 20, lat);
    check_eq("t3_relocked", bus.locked, 1'b1);

    // Illegal pattern, then recovery with no predecessor.
    drive_pat(4'b1010, 20, lat);
    check_eq("t4_step_valid", bus.step_valid, 1'b0);
    check_eq("t4_locked", bus.locked, 1'b0);
    drive_pat(4'b0011, 20, lat);
    check_eq("t4_step", bus.step, 3'd6);
    check_eq("t4_step_valid2", bus.step_valid, 1'b1);
    check_eq("t4_err_count", bus.err_count, m_errcnt);

    // Two-cycle glitch must be rejected.
    drive_pat(4'b1000, 20, lat);
    s0 = strobe_cnt;
    @(negedge exCLK);
    bus.q_in = 4'b1100;
    repeat (2) @(posedge exCLK);
    #1;
    bus.q_in = 4'b1000;
    repeat (20) @(posedge exCLK);
    #1;
    check_eq("t5_strobes", strobe_cnt - s0, 0);
    check_eq("t5_step", bus.step, 3'd1);

    // Error counter saturation.
    for (int k = 0; k < 300; k++) begin
      drive_pat(((k % 2) == 0) ? 4'b1010 : 4'b0101, 9, lat);
    end
    check_eq("t6_err_sat", bus.err_count, 8'd255);
    check_eq("t6_model_sat", bus.err_count, m_errcnt);
    @(negedge exCLK);
    check_eq("sb_drained", sb_q.size(), 0);

    // Reset in the middle of a debounce window.
    bus.q_in = 4'b0000;
    repeat (3) @(posedge exCLK);
    @(negedge exCLK);
    rst = 1'b1;
    @(negedge exCLK);
    check_reset_outputs("t6_rst");
    repeat (8) @(posedge exCLK);
    @(negedge exCLK);
    check_reset_outputs("t6_rst_hold");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
